// File: rtl/user_event_arbiter.sv
// user_event_arbiter: merges keyboard and gamepad event sources into one
// show-ahead event FIFO. EV_NEW_GAME is always granted first. Other fresh events
// and held-key auto-repeats are each arbitrated round-robin.

package user_event_pkg;
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_DOWN     = 3'd3,
    EV_ROTATE   = 3'd4,
    EV_NEW_GAME = 3'd5
  } user_event_t;
endpackage

module user_event_arbiter
  import user_event_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  user_event_t src0_event_i,
  input  logic        src0_valid_i,
  output logic        src0_ready_o,
  input  logic        src0_hold_i,
  input  user_event_t src1_event_i,
  input  logic        src1_valid_i,
  output logic        src1_ready_o,
  input  logic        src1_hold_i,
  output user_event_t user_event_o,
  output logic        user_event_ready_o,
  input  logic        user_event_rd_req_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DLY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LOAD = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_PEND, R_RATE} rpt_state_t;

  // FIFO storage and control
  user_event_t      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Arbitration state
  logic             fresh_ptr;
  logic             rpt_ptr;

  // Per-source repeat machines
  rpt_state_t       rpt_state [2];
  logic [CW-1:0]    rpt_cnt   [2];
  user_event_t      rpt_ev    [2];

  user_event_t      src_ev [2];
  logic [1:0]       hold;
  logic [1:0]       f_vld;
  logic [1:0]       f_ng;
  logic [1:0]       r_req;
  logic [1:0]       gnt_f;
  logic [1:0]       gnt_r;
  logic             pop;
  logic             full;
  logic             wr_ok;
  logic             flush;
  logic             wr_en;
  user_event_t      wr_data;

  // Only movement events auto-repeat while the key is held
  function automatic logic is_repeatable(input user_event_t e);
    return (e == EV_LEFT) || (e == EV_RIGHT) || (e == EV_DOWN);
  endfunction

  assign src_ev[0] = src0_event_i;
  assign src_ev[1] = src1_event_i;
  assign hold      = {src1_hold_i, src0_hold_i};
  assign f_vld     = {src1_valid_i, src0_valid_i};
  assign f_ng      = {src1_valid_i && (src1_event_i == EV_NEW_GAME),
                      src0_valid_i && (src0_event_i == EV_NEW_GAME)};
  // A pending repeat is withdrawn as soon as its key is released
  assign r_req     = {(rpt_state[1] == R_PEND) && hold[1],
                      (rpt_state[0] == R_PEND) && hold[0]};

  assign pop   = user_event_rd_req_i && (count != '0);
  assign full  = (count == DEPTH_C);
  assign wr_ok = !full || pop;
  // Only a full FIFO with no pop can block EV_NEW_GAME; it then replaces the backlog
  assign flush = (|f_ng) && !wr_ok;

  // Grant selection: new-game first, then fresh round-robin, then repeat round-robin
  always_comb begin
    gnt_f = 2'b00;
    gnt_r = 2'b00;
    if (!srst_n_i) begin
      gnt_f = 2'b00;
    end else if (f_ng[0]) begin
      gnt_f = 2'b01;
    end else if (f_ng[1]) begin
      gnt_f = 2'b10;
    end else if (wr_ok) begin
      if (f_vld == 2'b11)      gnt_f = fresh_ptr ? 2'b10 : 2'b01;
      else if (|f_vld)         gnt_f = f_vld;
      else if (r_req == 2'b11) gnt_r = rpt_ptr ? 2'b10 : 2'b01;
      else                     gnt_r = r_req;
    end
  end

  assign src0_ready_o = gnt_f[0];
  assign src1_ready_o = gnt_f[1];

  assign wr_en   = (|gnt_f) || (|gnt_r);
  assign wr_data = gnt_f[0] ? src0_event_i :
                   gnt_f[1] ? src1_event_i :
                   gnt_r[0] ? rpt_ev[0]    : rpt_ev[1];

  assign user_event_ready_o = (count != '0);
  assign user_event_o       = (count != '0) ? mem[rd_ptr] : EV_NONE;

  // FIFO payload; occupancy is tracked separately so the payload needs no reset
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy, including the new-game flush
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + AW'(1);
      count  <= (AW+1)'(1);
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Round-robin pointers, one for fresh events and one for repeats
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      fresh_ptr <= 1'b0;
      rpt_ptr   <= 1'b0;
    end else begin
      if (|gnt_f) fresh_ptr <= ~fresh_ptr;
      if (|gnt_r) rpt_ptr   <= ~rpt_ptr;
    end
  end

  // Auto-repeat machines; a fresh grant from the same source always restarts them
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < 2; n++) begin
      if (!srst_n_i) begin
        rpt_state[n] <= R_IDLE;
        rpt_cnt[n]   <= '0;
        rpt_ev[n]    <= EV_NONE;
      end else if (gnt_f[n]) begin
        if (is_repeatable(src_ev[n]) && hold[n]) begin
          rpt_state[n] <= R_DELAY;
          rpt_cnt[n]   <= DLY_LOAD;
          rpt_ev[n]    <= src_ev[n];
        end else begin
          rpt_state[n] <= R_IDLE;
        end
      end else if ((rpt_state[n] != R_IDLE) && !hold[n]) begin
        rpt_state[n] <= R_IDLE;
      end else begin
        case (rpt_state[n])
          R_DELAY, R_RATE: begin
            if (rpt_cnt[n] == '0) rpt_state[n] <= R_PEND;
            else                  rpt_cnt[n]   <= rpt_cnt[n] - CW'(1);
          end
          R_PEND: begin
            if (gnt_r[n]) begin
              rpt_state[n] <= R_RATE;
              rpt_cnt[n]   <= PER_LOAD;
            end
          end
          default: rpt_state[n] <= R_IDLE;
        endcase
      end
    end
  end

endmodule
